yc_separator_param: RTL and testbench
=====================================

# yc_separator_param

Parametrised composite-video luma/chroma separator for the capture front end, sitting between the ADC sample formatter and the colour demodulator. It computes a boxcar average over one subcarrier period (luma) and the centre-tap residual (chroma), both saturated to the data width. Unlike the fixed 21-tap separator it replaces, it is generic in width and window, advances only on qualified samples, suppresses output until the window is full, supports a line-start flush, and has run-time selectable modes.

## Interface
- DATA_W, 12, signed sample width of input and both outputs (8..16)
- WINDOW, 21, boxcar length in samples; odd, 3..63 (21 = NTSC at 74.25 MHz)
- FRAC_W, 16, fractional bits of the reciprocal; RECIP = round(2^FRAC_W / WINDOW), computed at elaboration
- clk  in  1  sole clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  data_in is a sample this cycle
- data_in  in  DATA_W  signed composite sample
- flush  in  1  synchronous clear of the window (line start)
- mode  in  2  0 = separate, 1 = bypass, 2 = chroma-kill, 3 = treated as 0
- out_valid  out  1  luma_out/chroma_out valid this cycle
- luma_out  out  DATA_W  signed luma
- chroma_out  out  DATA_W  signed chroma
- filled  out  1  window holds WINDOW accepted samples since reset/flush

## Operation
- Stage A, on accept (in_valid=1, flush=0):
  - Shift register advances.
  - acc <= acc + data_in - tap[WINDOW-1]; acc width DATA_W + clog2(WINDOW) + 1.
  - Fill counter increments, saturating at WINDOW.
  - Taps, acc and counter hold when in_valid=0.
- Stage B, every cycle:
  - Registers prod = acc * RECIP.
  - Registers the centre tap (index (WINDOW-1)/2 of the post-shift window, i.e. sample k-(WINDOW-1)/2 for newest sample k).
  - Registers mode and vA = (accept this cycle) AND (fill count == WINDOW after the update).
- Stage C, every cycle, out_valid <= vB:
  - avg = prod >>> FRAC_W (arithmetic floor), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Saturation is required: RECIP*WINDOW can exceed 2^FRAC_W.
  - Mode 0: luma = avg; chroma = sat(centre - avg), difference formed in DATA_W+2 bits.
  - Mode 1: luma = centre; chroma = 0.
  - Mode 2: luma = avg; chroma = 0.
  - When vB=0, luma/chroma hold their previous values.
- Mode is sampled per sample at stage B. A change takes effect on the next output with no glitch or flush.
- Flush:
  - Clears taps, acc, fill counter, and the stage B/C valid bits on the next edge.
  - A sample presented with flush=1 is dropped; flush has priority.
- filled is a registered copy of (fill count == WINDOW).

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, luma_out=0, chroma_out=0, filled=0; taps, acc, counter and pipeline cleared.
- Latency: sample accepted at edge E0 produces out_valid at edge E0+2 (two cycles), registered outputs.
- First out_valid follows the WINDOW-th accepted sample after reset/flush, then one output per accepted sample.
- Throughput: one sample per clock; no backpressure; gaps in in_valid produce matching gaps in out_valid with identical data.
- Flush at edge E: outputs already in stage B/C are discarded; out_valid is 0 from E+1 until WINDOW new samples are accepted.
- Reset deasserted mid-stream: behaves as a flush; no output until the window refills.

## Test plan
- Reset: hold rst_n=0 with random in_valid/data_in -> all outputs 0; after release, out_valid stays 0 for the first 20 accepted samples; filled rises after the 21st.
- DC 100, WINDOW=21, mode 0, continuous valid -> first out_valid 2 cycles after the 21st sample; luma=100, chroma=0 thereafter.
- Full-scale -2048 DC, mode 0 -> luma=-2048 (raw -2049 saturated), chroma=0; +2047 DC -> luma=2047, chroma=0.
- Alternating +500/-500 starting +500, mode 0:
  - First output: luma=23, chroma=477.
  - Next output: luma=-24, chroma=-476.
  - Same stream with random in_valid gaps -> identical output sequence.
- Alternating stream, then mode=1 -> luma=centre (+500/-500), chroma=0; mode=2 -> luma=23/-24, chroma=0; switch lands on exactly the next sample.
- DC 100 stream, flush asserted together with in_valid mid-stream -> out_valid low from the next edge; that sample is dropped; outputs resume after 21 further accepted samples.

Source files
------------

// File: rtl/yc_separator_param_if.sv
// Sample/result bundle for the luma/chroma separator.
// The master side drives samples; the slave side (the separator) returns results.
interface yc_separator_param_if #(
  parameter int DATA_W = 12
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] data_in;
  logic                     flush;
  logic [1:0]               mode;
  logic                     out_valid;
  logic signed [DATA_W-1:0] luma_out;
  logic signed [DATA_W-1:0] chroma_out;
  logic                     filled;

  modport master (
    output in_valid, data_in, flush, mode,
    input  out_valid, luma_out, chroma_out, filled
  );

  modport slave (
    input  in_valid, data_in, flush, mode,
    output out_valid, luma_out, chroma_out, filled
  );
endinterface

// File: rtl/yc_separator_param.sv
// Composite-video luma/chroma separator: a boxcar mean over one subcarrier
// period gives luma, and the centre-tap residual gives chroma.
module yc_separator_param #(
  parameter int DATA_W = 12,
  parameter int WINDOW = 21,
  parameter int FRAC_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  yc_separator_param_if.slave bus
);
  localparam int CNT_W   = $clog2(WINDOW + 1);
  localparam int ACC_W   = DATA_W + $clog2(WINDOW) + 1;
  localparam int RC_W    = FRAC_W + 2;
  localparam int PROD_W  = ACC_W + RC_W;
  localparam int DIFF_W  = DATA_W + 2;
  localparam int CENTRE  = (WINDOW - 1) / 2;
  localparam int RECIP_I = ((32'sd1 <<< FRAC_W) + WINDOW / 32'sd2) / WINDOW;
  localparam logic signed [RC_W-1:0]   RECIP = RC_W'(RECIP_I);
  localparam logic [CNT_W-1:0]         FULL  = CNT_W'(WINDOW);
  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] sat_dw(input logic signed [PROD_W-1:0] v);
    logic signed [PROD_W-1:0] hi;
    logic signed [PROD_W-1:0] lo;
    hi = {{(PROD_W-DATA_W){1'b0}}, MAX_V};
    lo = {{(PROD_W-DATA_W){1'b1}}, MIN_V};
    if (v > hi) begin
      sat_dw = MAX_V;
    end else if (v < lo) begin
      sat_dw = MIN_V;
    end else begin
      sat_dw = v[DATA_W-1:0];
    end
  endfunction

  logic signed [DATA_W-1:0] r_taps [WINDOW];
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_va;
  logic                     r_filled;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [DATA_W-1:0] r_centre;
  logic [1:0]               r_mode;
  logic                     r_vb;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_luma;
  logic signed [DATA_W-1:0] r_chroma;

  logic                     w_accept;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]         w_cnt_next;
  logic signed [PROD_W-1:0] w_avg_full;
  logic signed [DATA_W-1:0] w_avg;
  logic signed [DIFF_W-1:0] w_diff;
  logic signed [DATA_W-1:0] w_luma_sel;
  logic signed [DATA_W-1:0] w_chroma_sel;

  // Running-sum update and saturating fill count for an accepted sample.
  always_comb begin
    w_accept   = bus.in_valid & ~bus.flush;
    w_acc_next = r_acc + ACC_W'(bus.data_in) - ACC_W'(r_taps[WINDOW-1]);
    if (r_cnt == FULL) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CNT_W'(1'b1);
    end
  end

  // Stage A: window shift register, running sum and fill state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WINDOW; i++) r_taps[i] <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_va     <= 1'b0;
      r_filled <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < WINDOW; i++) r_taps[i] <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_va     <= 1'b0;
      r_filled <= 1'b0;
    end else begin
      r_va <= w_accept && (w_cnt_next == FULL);
      if (w_accept) begin
        r_taps[0] <= bus.data_in;
        for (int i = 1; i < WINDOW; i++) r_taps[i] <= r_taps[i-1];
        r_acc    <= w_acc_next;
        r_cnt    <= w_cnt_next;
        r_filled <= (w_cnt_next == FULL);
      end
    end
  end

  // Stage B: reciprocal multiply, centre tap and per-sample mode capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_centre <= '0;
      r_mode   <= 2'd0;
      r_vb     <= 1'b0;
    end else begin
      r_prod   <= PROD_W'(r_acc) * PROD_W'(RECIP);
      r_centre <= r_taps[CENTRE];
      r_mode   <= bus.mode;
      r_vb     <= bus.flush ? 1'b0 : r_va;
    end
  end

  // Floor-scaled mean, saturated because RECIP*WINDOW may exceed unity.
  always_comb begin
    w_avg_full = r_prod >>> FRAC_W;
    w_avg      = sat_dw(w_avg_full);
    w_diff     = DIFF_W'(r_centre) - DIFF_W'(w_avg);
    case (r_mode)
      2'd1: begin
        w_luma_sel   = r_centre;
        w_chroma_sel = '0;
      end
      2'd2: begin
        w_luma_sel   = w_avg;
        w_chroma_sel = '0;
      end
      default: begin
        w_luma_sel   = w_avg;
        w_chroma_sel = sat_dw(PROD_W'(w_diff));
      end
    endcase
  end

  // Stage C: registered outputs; data holds across invalid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_luma      <= '0;
      r_chroma    <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_vb;
      if (r_vb) begin
        r_luma   <= w_luma_sel;
        r_chroma <= w_chroma_sel;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.luma_out   = r_luma;
  assign bus.chroma_out = r_chroma;
  assign bus.filled     = r_filled;
endmodule

// File: tb/tb_yc_separator_param.sv
// Self-checking bench for yc_separator_param: random and directed streams
// compared against a window-sum reference model with a two-edge latency.
module tb_yc_separator_param;
  localparam int DATA_W = 12;
  localparam int WINDOW = 21;
  localparam int FRAC_W = 16;
  localparam int CTR    = (WINDOW - 1) / 2;
  localparam int VMAX   = (1 << (DATA_W - 1)) - 1;
  localparam int VMIN   = -(1 << (DATA_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  yc_separator_param_if #(.DATA_W(DATA_W)) bus();

  yc_separator_param #(.DATA_W(DATA_W), .WINDOW(WINDOW), .FRAC_W(FRAC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad = 0;
  longint recip;
  int win[$];
  bit p1_v, p2_v, m_v, m_f;
  int p1_l, p1_c, p2_l, p2_c, m_l, m_c;
  logic [1:0] cur_mode = 2'd0;
  int alt_l[$];
  int alt_c[$];

  function automatic int sat(input longint x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return int'(x);
  endfunction

  function automatic int alt(input int k);
    return (k % 2 == 0) ? 500 : -500;
  endfunction

  task automatic model_reset();
    win.delete();
    p1_v = 0; p2_v = 0; m_v = 0; m_f = 0;
    p1_l = 0; p1_c = 0; p2_l = 0; p2_c = 0; m_l = 0; m_c = 0;
  endtask

  // One clock of stimulus; the model advances on the same edge.
  task automatic drive(input bit v, input int d, input bit fl);
    longint s;
    int avg, ctr;
    bus.in_valid = v;
    bus.data_in  = DATA_W'(d);
    bus.flush    = fl;
    bus.mode     = cur_mode;
    @(posedge clk);
    if (fl) begin
      win.delete();
      p1_v = 0; p2_v = 0; m_v = 0; m_f = 0;
    end else begin
      m_v = p2_v;
      if (p2_v) begin m_l = p2_l; m_c = p2_c; end
      p2_v = p1_v; p2_l = p1_l; p2_c = p1_c;
      p1_v = 0;
      if (v) begin
        win.push_back(d);
        if (win.size() > WINDOW) void'(win.pop_front());
        if (win.size() == WINDOW) begin
          s = 0;
          foreach (win[i]) s += win[i];
          avg = sat((s * recip) >>> FRAC_W);
          ctr = win[WINDOW - 1 - CTR];
          p1_v = 1;
          case (cur_mode)
            2'd1:    begin p1_l = ctr; p1_c = 0; end
            2'd2:    begin p1_l = avg; p1_c = 0; end
            default: begin p1_l = avg; p1_c = sat(longint'(ctr) - avg); end
          endcase
        end
      end
      m_f = (win.size() == WINDOW);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'($urandom);
      bus.data_in  = DATA_W'($urandom);
      bus.flush    = 1'b0;
      bus.mode     = 2'd0;
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.luma_out !== 12'sd0 || bus.chroma_out !== 12'sd0 || bus.filled !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got v=%b l=%0d c=%0d f=%b want all zero", i, bus.out_valid, bus.luma_out, bus.chroma_out, bus.filled);
      end
    end
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < WINDOW + 2; i++) begin
      drive(i < WINDOW, $urandom_range(4095) - 2048, 1'b0);
      total++;
      if (bus.out_valid !== m_v || int'(bus.luma_out) !== m_l || int'(bus.chroma_out) !== m_c || bus.filled !== m_f) begin
        bad++;
        $display("FAIL reset_fill cyc=%0d got v=%b l=%0d c=%0d f=%b want v=%b l=%0d c=%0d f=%b", i, bus.out_valid, bus.luma_out, bus.chroma_out, bus.filled, m_v, m_l, m_c, m_f);
      end
      total++;
      if (bus.filled !== (i >= WINDOW - 1) || bus.out_valid !== (i == WINDOW + 1)) begin
        bad++;
        $display("FAIL reset_edges cyc=%0d got f=%b v=%b want f=%b v=%b", i, bus.filled, bus.out_valid, i >= WINDOW - 1, i == WINDOW + 1);
      end
    end
  endtask

  task automatic test_dc(input int val);
    int nv = 0;
    cur_mode = 2'd0;
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, val, 1'b0);
      total++;
      if (bus.out_valid !== m_v || int'(bus.luma_out) !== m_l || int'(bus.chroma_out) !== m_c || bus.filled !== m_f) begin
        bad++;
        $display("FAIL dc_%0d cyc=%0d got v=%b l=%0d c=%0d want v=%b l=%0d c=%0d", val, i, bus.out_valid, bus.luma_out, bus.chroma_out, m_v, m_l, m_c);
      end
      if (bus.out_valid === 1'b1) begin
        nv++;
        total++;
        if (int'(bus.luma_out) !== val || bus.chroma_out !== 12'sd0) begin
          bad++;
          $display("FAIL dc_level_%0d cyc=%0d got l=%0d c=%0d want l=%0d c=0", val, i, bus.luma_out, bus.chroma_out, val);
        end
      end
    end
    total++;
    if (nv !== 30 - (WINDOW + 1)) begin
      bad++;
      $display("FAIL dc_count_%0d got %0d outputs want %0d", val, nv, 30 - (WINDOW + 1));
    end
  endtask

  task automatic test_alternating();
    int nv = 0;
    cur_mode = 2'd0;
    alt_l.delete(); alt_c.delete();
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      drive(i < 30, alt(i), 1'b0);
      if (m_v) begin alt_l.push_back(m_l); alt_c.push_back(m_c); end
      total++;
      if (bus.out_valid !== m_v || int'(bus.luma_out) !== m_l || int'(bus.chroma_out) !== m_c) begin
        bad++;
        $display("FAIL alternating cyc=%0d got v=%b l=%0d c=%0d want v=%b l=%0d c=%0d", i, bus.out_valid, bus.luma_out, bus.chroma_out, m_v, m_l, m_c);
      end
      if (bus.out_valid === 1'b1 && nv < 2) begin
        total++;
        if (int'(bus.luma_out) !== (nv == 0 ? 23 : -24) || int'(bus.chroma_out) !== (nv == 0 ? 477 : -476)) begin
          bad++;
          $display("FAIL alt_first out=%0d got l=%0d c=%0d want l=%0d c=%0d", nv, bus.luma_out, bus.chroma_out, nv == 0 ? 23 : -24, nv == 0 ? 477 : -476);
        end
        nv++;
      end
    end
  endtask

  task automatic test_gaps();
    int k = 0;
    int nv = 0;
    cur_mode = 2'd0;
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 400 && (k < 30 || i < 200); i++) begin
      bit v;
      v = (k < 30) && ($urandom_range(2) != 0);
      drive(v, v ? alt(k) : $urandom_range(4095) - 2048, 1'b0);
      if (v) k++;
      total++;
      if (bus.out_valid !== m_v || int'(bus.luma_out) !== m_l || int'(bus.chroma_out) !== m_c) begin
        bad++;
        $display("FAIL gaps cyc=%0d got v=%b l=%0d c=%0d want v=%b l=%0d c=%0d", i, bus.out_valid, bus.luma_out, bus.chroma_out, m_v, m_l, m_c);
      end
      if (bus.out_valid === 1'b1) begin
        total++;
        if (nv >= alt_l.size() || int'(bus.luma_out) !== alt_l[nv] || int'(bus.chroma_out) !== alt_c[nv]) begin
          bad++;
          $display("FAIL gaps_sequence out=%0d got l=%0d c=%0d", nv, bus.luma_out, bus.chroma_out);
        end
        nv++;
      end
    end
    total++;
    if (nv !== alt_l.size()) begin
      bad++;
      $display("FAIL gaps_count got %0d outputs want %0d", nv, alt_l.size());
    end
  endtask

  task automatic test_modes();
    int k = 0;
    cur_mode = 2'd0;
    drive(1'b0, 0, 1'b1);
    for (int ph = 0; ph < 4; ph++) begin
      bit first = 1;
      for (int j = 0; j < 3; j++) drive(1'b0, 0, 1'b0);
      cur_mode = (ph == 0) ? 2'd0 : 2'(ph);
      for (int i = 0; i < ((ph == 0) ? 24 : 8); i++) begin
        drive(1'b1, alt(k), 1'b0);
        k++;
        total++;
        if (bus.out_valid !== m_v || int'(bus.luma_out) !== m_l || int'(bus.chroma_out) !== m_c) begin
          bad++;
          $display("FAIL mode%0d cyc=%0d got v=%b l=%0d c=%0d want v=%b l=%0d c=%0d", cur_mode, i, bus.out_valid, bus.luma_out, bus.chroma_out, m_v, m_l, m_c);
        end
        if (ph == 1 && bus.out_valid === 1'b1 && first) begin
          first = 0;
          total++;
          if ((int'(bus.luma_out) !== 500 && int'(bus.luma_out) !== -500) || bus.chroma_out !== 12'sd0) begin
            bad++;
            $display("FAIL mode_bypass_first got l=%0d c=%0d want l=+-500 c=0", bus.luma_out, bus.chroma_out);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    int nv = 0;
    cur_mode = 2'd0;
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 25; i++) drive(1'b1, 100, 1'b0);
    drive(1'b1, 100, 1'b1);
    total++;
    if (bus.out_valid !== 1'b0 || bus.filled !== 1'b0) begin
      bad++;
      $display("FAIL flush_edge got v=%b f=%b want v=0 f=0", bus.out_valid, bus.filled);
    end
    for (int i = 0; i < WINDOW + 2; i++) begin
      drive(i < WINDOW, 100, 1'b0);
      total++;
      if (bus.out_valid !== m_v || int'(bus.luma_out) !== m_l || int'(bus.chroma_out) !== m_c || bus.filled !== m_f) begin
        bad++;
        $display("FAIL flush_refill cyc=%0d got v=%b l=%0d c=%0d f=%b want v=%b l=%0d c=%0d f=%b", i, bus.out_valid, bus.luma_out, bus.chroma_out, bus.filled, m_v, m_l, m_c, m_f);
      end
      if (bus.out_valid === 1'b1) nv++;
    end
    total++;
    if (nv !== 1 || bus.out_valid !== 1'b1 || int'(bus.luma_out) !== 100) begin
      bad++;
      $display("FAIL flush_resume got %0d outputs last l=%0d want 1 output l=100", nv, bus.luma_out);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    bus.flush    = 1'b0;
    bus.mode     = 2'd0;
    recip = longint'($rtoi((2.0 ** FRAC_W) / WINDOW + 0.5));
    model_reset();
    test_reset();
    test_dc(100);
    test_dc(-2048);
    test_dc(2047);
    test_alternating();
    test_gaps();
    test_modes();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
